// File: rtl/jam.sv
// Exhaustive 8x8 job-assignment solver: walks all 40320 permutations in lexicographic
// order, summing ROM costs, and reports the minimum total and how many permutations hit it.
module jam (
    input  logic       CLK,
    input  logic       RST,
    output logic [2:0] W,
    output logic [2:0] J,
    input  logic [6:0] Cost,
    output logic [3:0] MatchCount,
    output logic [8:0] MinCost,
    output logic       Valid
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        ACC    = 3'd1,
        UPDATE = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    logic [7:0][2:0] perm;
    logic [7:0][2:0] perm_swp;
    logic [7:0][2:0] perm_nxt;
    logic [9:0]      acc;
    logic [9:0]      best;
    logic [3:0]      count;
    logic            has_next;
    logic [2:0]      i_idx;
    logic [2:0]      j_idx;

    // Single-cycle next permutation: the suffix after i is descending, so the
    // rightmost element larger than perm[i] is also the smallest such element.
    always_comb begin
        has_next = 1'b0;
        i_idx    = 3'd0;
        j_idx    = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (perm[k] < perm[k+1]) begin
                has_next = 1'b1;
                i_idx    = 3'(k);
            end
        end
        for (int k = 1; k < 8; k++) begin
            if (3'(k) > i_idx && perm[k] > perm[i_idx])
                j_idx = 3'(k);
        end
        perm_swp        = perm;
        perm_swp[i_idx] = perm[j_idx];
        perm_swp[j_idx] = perm[i_idx];
        perm_nxt        = perm_swp;
        for (int k = 1; k < 8; k++) begin
            if (3'(k) > i_idx)
                perm_nxt[k] = perm_swp[3'(4'(i_idx) + 4'd8 - 4'(k))];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= FETCH;
            for (int k = 0; k < 8; k++) perm[k] <= 3'(k);
            acc        <= '0;
            best       <= '1;
            count      <= '0;
            W          <= '0;
            J          <= '0;
            MinCost    <= '0;
            MatchCount <= '0;
            Valid      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Cost arriving now belongs to the address of the previous cycle.
                    if (W != 3'd0)
                        acc <= acc + 10'(Cost);
                    if (W == 3'd7) begin
                        state <= ACC;
                    end else begin
                        W <= W + 3'd1;
                        J <= perm[W + 3'd1];
                    end
                end
                ACC: begin
                    acc   <= acc + 10'(Cost);
                    state <= UPDATE;
                end
                UPDATE: begin
                    if (acc < best) begin
                        best  <= acc;
                        count <= 4'd1;
                    end else if (acc == best && count != 4'd15) begin
                        count <= count + 4'd1;
                    end
                    acc   <= '0;
                    state <= NEXT;
                end
                NEXT: begin
                    if (has_next) begin
                        perm  <= perm_nxt;
                        W     <= 3'd0;
                        J     <= perm_nxt[0];
                        state <= FETCH;
                    end else begin
                        MinCost    <= best[8:0];
                        MatchCount <= count;
                        Valid      <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: state <= DONE;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_jam.sv
// Directed cost tables plus one random table checked against a subset-DP brute force;
// a bus monitor checks every 8-read burst is a permutation, in strictly increasing order.
module tb_jam;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost = '0;
    logic [3:0] MatchCount;
    logic [8:0] MinCost;
    logic       Valid;

    jam dut (
        .CLK        (CLK),
        .RST        (RST),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MatchCount (MatchCount),
        .MinCost    (MinCost),
        .Valid      (Valid)
    );

    always #5 CLK = ~CLK;

    // External ROM with one-cycle registered read.
    logic [6:0] rom [8][8];
    always @(posedge CLK) Cost <= rom[W][J];

    typedef struct packed {
        logic [63:0][6:0] cost;
        logic [8:0]       exp_min;
        logic [3:0]       exp_cnt;
    } vec_t;

    vec_t vecs [5];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: DP over assigned-job subsets (min, number of ways).
    function automatic void model(input logic [63:0][6:0] c, output int mn, output int cnt);
        int dmin [256];
        int dcnt [256];
        for (int m = 0; m < 256; m++) begin
            dmin[m] = 1 << 30;
            dcnt[m] = 0;
        end
        dmin[0] = 0;
        dcnt[0] = 1;
        for (int m = 0; m < 255; m++) begin
            if (dcnt[m] != 0) begin
                int w;
                w = $countones(m);
                for (int j = 0; j < 8; j++) begin
                    if (((m >> j) & 1) == 0) begin
                        int v;
                        int nm;
                        v  = dmin[m] + int'(c[w*8+j]);
                        nm = m | (1 << j);
                        if (v < dmin[nm]) begin
                            dmin[nm] = v;
                            dcnt[nm] = dcnt[m];
                        end else if (v == dmin[nm]) begin
                            dcnt[nm] = dcnt[nm] + dcnt[m];
                        end
                    end
                end
            end
        end
        mn  = dmin[255];
        cnt = (dcnt[255] > 15) ? 15 : dcnt[255];
    endfunction

    // Bus monitor
    int      hw [8];
    int      hj [8];
    int      hcnt, bursts, bad, rises;
    bit      pv;
    longint  prev_perm, id_val, rev_val;

    initial begin
        id_val  = 0;
        rev_val = 0;
        for (int k = 0; k < 8; k++) begin
            id_val  = (id_val << 3) | longint'(k);
            rev_val = (rev_val << 3) | longint'(7 - k);
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            hcnt = 0; bursts = 0; bad = 0; rises = 0; pv = 0; prev_perm = 0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                hw[k] = hw[k+1];
                hj[k] = hj[k+1];
            end
            hw[7] = int'(W);
            hj[7] = int'(J);
            if (hcnt < 8) hcnt++;
            if (Valid && !pv) rises++;
            pv = Valid;
            if (hcnt == 8) begin
                int     ok;
                int     mask;
                longint cur;
                ok = 1; mask = 0; cur = 0;
                for (int k = 0; k < 8; k++) begin
                    if (hw[k] != k) ok = 0;
                    mask = mask | (1 << hj[k]);
                    cur  = (cur << 3) | longint'(hj[k]);
                end
                if (ok != 0) begin
                    if (mask != 255) bad++;
                    if (bursts == 0 && cur != id_val) bad++;
                    if (bursts > 0 && cur <= prev_perm) bad++;
                    prev_perm = cur;
                    bursts++;
                end
            end
        end
    end

    task automatic run_case(input int idx, input bit abort);
        int n;
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                rom[w][j] = vecs[idx].cost[w*8+j];
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check($sformatf("v%0d reset outputs", idx), int'({W, J, MinCost, MatchCount, Valid}), 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        if (abort) begin
            repeat (1000) @(negedge CLK);
            check("abort valid low mid-run", int'(Valid), 0);
            #2 RST = 1'b0;
            #1 check("abort outputs cleared", int'({W, J, MinCost, MatchCount, Valid}), 0);
            repeat (2) @(posedge CLK);
            #1 RST = 1'b1;
        end
        n = 0;
        while (!Valid && n < 500000) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("v%0d valid within bound", idx), int'(Valid), 1);
        check($sformatf("v%0d MinCost", idx), int'(MinCost), int'(vecs[idx].exp_min));
        check($sformatf("v%0d MatchCount", idx), int'(MatchCount), int'(vecs[idx].exp_cnt));
        check($sformatf("v%0d bursts", idx), bursts, 40320);
        check($sformatf("v%0d bad bursts", idx), bad, 0);
        check($sformatf("v%0d last burst reversed", idx), int'(prev_perm == rev_val), 1);
        repeat (5) @(negedge CLK);
        check($sformatf("v%0d outputs held", idx), int'({Valid, MinCost, MatchCount}),
              int'({1'b1, vecs[idx].exp_min, vecs[idx].exp_cnt}));
        check($sformatf("v%0d valid rises once", idx), rises, 1);
    endtask

    initial begin
        int mn, cnt;
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                vecs[0].cost[w*8+j] = 7'd1;
                vecs[1].cost[w*8+j] = (w == j) ? 7'd0 : 7'd100;
                vecs[2].cost[w*8+j] = (j == 7 - w) ? 7'd1 : 7'd50;
                vecs[3].cost[w*8+j] = (j == 7 - w) ? 7'd1 : 7'd50;
                vecs[4].cost[w*8+j] = 7'($urandom_range(0, 127));
            end
        end
        vecs[3].cost[0*8+6] = 7'd1;
        vecs[3].cost[1*8+7] = 7'd1;
        vecs[0].exp_min = 9'd8; vecs[0].exp_cnt = 4'd15;
        vecs[1].exp_min = 9'd0; vecs[1].exp_cnt = 4'd1;
        vecs[2].exp_min = 9'd8; vecs[2].exp_cnt = 4'd1;
        vecs[3].exp_min = 9'd8; vecs[3].exp_cnt = 4'd2;
        model(vecs[4].cost, mn, cnt);
        vecs[4].exp_min = 9'(mn);
        vecs[4].exp_cnt = 4'(cnt);

        for (int i = 0; i < 5; i++)
            run_case(i, i == 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
